// File: rtl/led_logic_pkg.sv
// ---------------------------------------------------------------------------
// led_logic_pkg
//   Shared constants, types and helpers for the LED strip sweeper.
//
//   LED_COUNT : number of LEDs on the strip (16)
//   POS_W     : width of the lit-LED position (4)
//   dir_t     : sweep direction, UP = toward higher bit index
//   onehot16  : position -> 16-bit one-hot LED mask
// ---------------------------------------------------------------------------
package led_logic_pkg;

  localparam int LED_COUNT = 16;
  localparam int POS_W     = 4;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  function automatic logic [LED_COUNT-1:0] onehot16(input logic [POS_W-1:0] pos);
    logic [LED_COUNT-1:0] mask;
    mask      = '0;
    mask[pos] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/led_logic_ok_sync.sv
// ---------------------------------------------------------------------------
// ok_sync_edge
//   Brings the asynchronous `ok` toggle into the clock domain and turns every
//   level change into a one-cycle step pulse.
//
//   Parameters:
//     SYNC_STAGES : synchronizer depth, must be 2 or more
//   Ports:
//     clk_i  in  1 : rising-edge clock
//     rst_i  in  1 : synchronous active-high reset, clears chain and history
//     ok_i   in  1 : asynchronous toggle input
//     step_o out 1 : high for one cycle per synchronized level change of ok_i
// ---------------------------------------------------------------------------
module ok_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ok_i,
  output logic step_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ok_i};
    prev_d = sync_out;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // prev resets to 0, so an ok already high at reset release yields one step.
  assign step_o = sync_out ^ prev_q;

endmodule

// File: rtl/led_logic.sv
// ---------------------------------------------------------------------------
// led_logic
//   Bounces a single lit LED across a 16-LED strip, one position per level
//   change of the `ok` toggle. Endpoints are lit once per pass, giving a
//   30-step sweep period.
//
//   Parameters:
//     SYNC_STAGES : synchronizer depth on ok (>= 2); latency = SYNC_STAGES+2
//   Ports:
//     CLOCK      in  1  : rising-edge clock
//     RESET      in  1  : synchronous active-high reset
//     ok         in  1  : asynchronous step toggle
//     LEDs_strip out 16 : registered LED drive, bit 0 = leftmost, 1 = lit
//
//   Build option:
//     LED_LOGIC_TRAIL_EN : also light the previous position (two-LED trail)
//
//   state (dir) | meaning
//   ------------+-------------------------------------------------
//   UP          | pos increments per step; at 15 turns to DOWN, 14
//   DOWN        | pos decrements per step; at 0 turns to UP, 1
// ---------------------------------------------------------------------------
module led_logic
  import led_logic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 ok,
  output logic [LED_COUNT-1:0] LEDs_strip
);

  logic                 step;
  logic [POS_W-1:0]     pos_q;
  logic [POS_W-1:0]     pos_d;
  dir_t                 dir_q;
  dir_t                 dir_d;
  logic [LED_COUNT-1:0] leds_q;
  logic [LED_COUNT-1:0] leds_d;
  logic [LED_COUNT-1:0] trail_mask;

  ok_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ok_sync (
    .clk_i  (CLOCK),
    .rst_i  (RESET),
    .ok_i   (ok),
    .step_o (step)
  );

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (step) begin
      if (dir_q == UP) begin
        if (pos_q == POS_W'(LED_COUNT - 1)) begin
          dir_d = DOWN;
          pos_d = POS_W'(LED_COUNT - 2);
        end else begin
          pos_d = pos_q + POS_W'(1);
        end
      end else begin
        if (pos_q == POS_W'(0)) begin
          dir_d = UP;
          pos_d = POS_W'(1);
        end else begin
          pos_d = pos_q - POS_W'(1);
        end
      end
    end
  end

`ifdef LED_LOGIC_TRAIL_EN
  logic [POS_W-1:0] last_pos_q;
  logic             trail_valid_q;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      last_pos_q    <= '0;
      trail_valid_q <= 1'b0;
    end else if (step) begin
      last_pos_q    <= pos_q;
      trail_valid_q <= 1'b1;
    end
  end

  always_comb begin
    trail_mask = '0;
    if (trail_valid_q) begin
      trail_mask = onehot16(last_pos_q);
    end
  end
`else
  always_comb begin
    trail_mask = '0;
  end
`endif

  // Output is registered from the current position, so it trails pos by one edge.
  always_comb begin
    leds_d = onehot16(pos_q) | trail_mask;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      pos_q  <= '0;
      dir_q  <= UP;
      leds_q <= onehot16(POS_W'(0));
    end else begin
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      leds_q <= leds_d;
    end
  end

  assign LEDs_strip = leds_q;

endmodule

// File: tb/tb_led_logic.sv
module tb_led_logic;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        ok;
  logic [15:0] LEDs_strip;

  int errors  = 0;
  int checks  = 0;
  int n_steps = 0;

  led_logic #(.SYNC_STAGES(2)) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .ok         (ok),
    .LEDs_strip (LEDs_strip)
  );

  always #5 CLOCK = ~CLOCK;

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  // Reference: position after n steps of a 30-step bounce 0..15..1.
  function automatic int sweep_pos(input int n);
    int p;
    p = n % 30;
    return (p <= 15) ? p : 30 - p;
  endfunction

  function automatic logic [15:0] expect_leds(input int n);
    logic [15:0] v;
    v = 16'h0001 << sweep_pos(n);
`ifdef LED_LOGIC_TRAIL_EN
    if (n > 0) v = v | (16'h0001 << sweep_pos(n - 1));
`endif
    return v;
  endfunction

  task automatic do_reset(input logic ok_level);
    RESET = 1'b1;
    ok    = ok_level;
    tick(2);
    RESET   = 1'b0;
    n_steps = 0;
  endtask

  task automatic toggle(input int gap);
    ok      = ~ok;
    n_steps = n_steps + 1;
    tick(gap);
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    checks++;
    if (LEDs_strip !== 16'h0001) begin
      errors++;
      $display("FAIL reset_value: got %h expected %h", LEDs_strip, 16'h0001);
    end
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checks++;
      if (LEDs_strip !== 16'h0001) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got %h expected %h", i, LEDs_strip, 16'h0001);
      end
    end
  endtask

  task automatic test_single_toggle;
    logic [15:0] exp1;
    do_reset(1'b0);
    ok = 1'b1;            // changes before edge k
    n_steps = 1;
    exp1 = expect_leds(1);
    tick(3);              // after edge k+2: not yet visible
    checks++;
    if (LEDs_strip !== 16'h0001) begin
      errors++;
      $display("FAIL latency_early: got %h expected %h", LEDs_strip, 16'h0001);
    end
    tick(1);              // after edge k+3
    checks++;
    if (LEDs_strip !== exp1) begin
      errors++;
      $display("FAIL latency_k3: got %h expected %h", LEDs_strip, exp1);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++;
      if (LEDs_strip !== exp1) begin
        errors++;
        $display("FAIL hold_high cyc %0d: got %h expected %h", i, LEDs_strip, exp1);
      end
    end
  endtask

  task automatic test_full_sweep;
    logic [15:0] e;
    do_reset(1'b0);
    for (int i = 1; i <= 31; i++) begin
      toggle(2);          // minimum legal spacing
      if (i == 15 || i == 16 || i == 30 || i == 31) begin
        tick(4);
        e = expect_leds(n_steps);
        checks++;
        if (LEDs_strip !== e) begin
          errors++;
          $display("FAIL sweep step %0d: got %h expected %h", i, LEDs_strip, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid_sweep;
    logic [15:0] e;
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) toggle(3);
    tick(4);
    e = expect_leds(7);
    checks++;
    if (LEDs_strip !== e) begin
      errors++;
      $display("FAIL mid_sweep_pre: got %h expected %h", LEDs_strip, e);
    end
    ok = 1'b0;            // 8th toggle, before edge k
    tick(2);              // after edge k+1: step is pending for edge k+2
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    n_steps = 0;
    checks++;
    if (LEDs_strip !== 16'h0001) begin
      errors++;
      $display("FAIL mid_sweep_reset: got %h expected %h", LEDs_strip, 16'h0001);
    end
    tick(10);
    checks++;
    if (LEDs_strip !== 16'h0001) begin
      errors++;
      $display("FAIL mid_sweep_discard: got %h expected %h", LEDs_strip, 16'h0001);
    end
  endtask

  task automatic test_freeze;
    logic [15:0] e;
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) toggle(3);
    tick(4);
    e = expect_leds(5);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (LEDs_strip !== e) begin
        errors++;
        $display("FAIL freeze cyc %0d: got %h expected %h", i * 10, LEDs_strip, e);
      end
      tick(10);
    end
  endtask

  task automatic test_ok_high_at_reset;
    logic [15:0] e;
    do_reset(1'b1);
    n_steps = 1;
    tick(6);
    e = expect_leds(1);
    checks++;
    if (LEDs_strip !== e) begin
      errors++;
      $display("FAIL ok_high_reset: got %h expected %h", LEDs_strip, e);
    end
    tick(10);
    checks++;
    if (LEDs_strip !== e) begin
      errors++;
      $display("FAIL ok_high_hold: got %h expected %h", LEDs_strip, e);
    end
  endtask

  task automatic test_random;
    int          gap;
    logic [15:0] e;
    do_reset(1'b0);
    for (int i = 0; i < 80; i++) begin
      gap = int'($urandom_range(7, 2));
      toggle(gap);
      if (gap >= 4) begin
        e = expect_leds(n_steps);
        checks++;
        if (LEDs_strip !== e) begin
          errors++;
          $display("FAIL random step %0d gap %0d: got %h expected %h",
                   n_steps, gap, LEDs_strip, e);
        end
      end
    end
    tick(4);
    e = expect_leds(n_steps);
    checks++;
    if (LEDs_strip !== e) begin
      errors++;
      $display("FAIL random_final step %0d: got %h expected %h", n_steps, LEDs_strip, e);
    end
  endtask

  initial begin
    RESET = 1'b1;
    ok    = 1'b0;
    test_reset;
    test_single_toggle;
    test_full_sweep;
    test_reset_mid_sweep;
    test_freeze;
    test_ok_high_at_reset;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
